// File: rtl/alu_control_md_if.sv
// Handshake/bus bundle between datapath control and the ALU control + mult/div block.
// ALU_MD_FLUSH_EN adds the md_flush input.
interface alu_control_md_if #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
);
  logic [1:0]        alu_op;
  logic [5:0]        funct;
  logic              issue;
  logic [WIDTH-1:0]  src_a;
  logic [WIDTH-1:0]  src_b;
  logic [CTRL_W-1:0] alu_ctrl;
  logic              illegal;
  logic              md_busy;
  logic              md_done;
  logic              stall;
  logic [WIDTH-1:0]  hi;
  logic [WIDTH-1:0]  lo;
`ifdef ALU_MD_FLUSH_EN
  logic              md_flush;
`endif

  modport master (
    output alu_op, funct, issue, src_a, src_b,
    input  alu_ctrl, illegal, md_busy, md_done, stall, hi, lo
`ifdef ALU_MD_FLUSH_EN
    , output md_flush
`endif
  );

  modport slave (
    input  alu_op, funct, issue, src_a, src_b,
    output alu_ctrl, illegal, md_busy, md_done, stall, hi, lo
`ifdef ALU_MD_FLUSH_EN
    , input md_flush
`endif
  );
endinterface

// File: rtl/alu_control_md.sv
// ALU control decoder plus iterative WIDTH-cycle multiply/divide sequencer with HI/LO.
// Define ALU_MD_FLUSH_EN to add md_flush, which aborts a running mult/div.
module alu_control_md #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  alu_control_md_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic [WIDTH-1:0]   r_acc_hi, r_acc_lo, r_opb;
  logic               r_is_div, r_neg_q, r_neg_r, r_dz, r_done;

  logic [3:0]         w_code;
  logic               w_ill;
  logic [CTRL_W-1:0]  w_ctrl;
  logic               w_alu10, w_md_op, w_mt_hi, w_mt_lo, w_hilo_op;
  logic               w_busy, w_flush, w_accept, w_start, w_last;
  logic               w_neg_a, w_neg_b;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;

  always_comb begin
    w_code = 4'b0000;
    w_ill  = 1'b0;
    unique case (bus.alu_op)
      2'b00: w_code = 4'b0010;
      2'b01: w_code = 4'b0110;
      2'b11: w_code = 4'b0111;
      default: begin
        unique case (bus.funct)
          6'b100100: w_code = 4'b0000;
          6'b100101: w_code = 4'b0001;
          6'b100000: w_code = 4'b0010;
          6'b100010: w_code = 4'b0110;
          6'b101010: w_code = 4'b0111;
          6'b100110: w_code = 4'b0011;
          6'b100111: w_code = 4'b1100;
          6'b000000: w_code = 4'b1000;
          6'b000010: w_code = 4'b1001;
          6'b000011: w_code = 4'b1010;
          6'b010000: w_code = 4'b1101;
          6'b010010: w_code = 4'b1110;
          6'b011000, 6'b011001, 6'b011010, 6'b011011,
          6'b010001, 6'b010011: w_code = 4'b0000;
          default:   w_ill  = 1'b1;
        endcase
      end
    endcase
  end

  always_comb begin
    w_ctrl      = '0;
    w_ctrl[3:0] = w_code;
  end

  assign w_alu10   = (bus.alu_op == 2'b10);
  assign w_md_op   = w_alu10 && (bus.funct[5:2] == 4'b0110);
  assign w_mt_hi   = w_alu10 && (bus.funct == 6'b010001);
  assign w_mt_lo   = w_alu10 && (bus.funct == 6'b010011);
  assign w_hilo_op = w_md_op | w_mt_hi | w_mt_lo |
                     (w_alu10 && ((bus.funct == 6'b010000) || (bus.funct == 6'b010010)));

`ifdef ALU_MD_FLUSH_EN
  assign w_flush = bus.md_flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_busy   = (r_state == S_RUN);
  // A flush, even in IDLE, swallows whatever is issued alongside it.
  assign w_accept = ~w_busy & bus.issue & ~w_flush;
  assign w_start  = w_accept & w_md_op;
  assign w_last   = w_busy & ~w_flush & (r_cnt == CNT_W'(1));

  // Signed ops (funct[0]=0) run on magnitudes; signs are reapplied at the end.
  assign w_neg_a = ~bus.funct[0] & bus.src_a[WIDTH-1];
  assign w_neg_b = ~bus.funct[0] & bus.src_b[WIDTH-1];
  assign w_mag_a = w_neg_a ? -bus.src_a : bus.src_a;
  assign w_mag_b = w_neg_b ? -bus.src_b : bus.src_b;

  // One iteration: shift-add multiply or restoring divide on {acc_hi, acc_lo}.
  logic [WIDTH:0]     w_add, w_shl, w_sub;
  logic               w_ge;
  logic [WIDTH-1:0]   w_it_hi, w_it_lo, w_quo, w_rem;
  logic [2*WIDTH-1:0] w_prod, w_prod_s;

  assign w_add   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opb} : '0);
  assign w_shl   = {r_acc_hi, r_acc_lo[WIDTH-1]};
  assign w_sub   = w_shl - {1'b0, r_opb};
  assign w_ge    = ~w_sub[WIDTH];
  assign w_it_hi = r_is_div ? (w_ge ? w_sub[WIDTH-1:0] : w_shl[WIDTH-1:0]) : w_add[WIDTH:1];
  assign w_it_lo = r_is_div ? {r_acc_lo[WIDTH-2:0], w_ge} : {w_add[0], r_acc_lo[WIDTH-1:1]};

  assign w_prod   = {w_it_hi, w_it_lo};
  assign w_prod_s = r_neg_q ? -w_prod : w_prod;
  assign w_quo    = r_dz ? '1 : (r_neg_q ? -w_it_lo : w_it_lo);
  assign w_rem    = r_neg_r ? -w_it_hi : w_it_hi;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_RUN;
      default: if (w_flush || (r_cnt == CNT_W'(1))) w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_opb    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_busy) begin
        r_cnt    <= w_flush ? '0 : r_cnt - CNT_W'(1);
        r_acc_hi <= w_it_hi;
        r_acc_lo <= w_it_lo;
        if (w_last) begin
          if (r_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end else begin
            {r_hi, r_lo} <= w_prod_s;
          end
        end
      end else if (w_start) begin
        r_cnt    <= CNT_W'(WIDTH);
        r_acc_hi <= '0;
        r_acc_lo <= w_mag_a;
        r_opb    <= w_mag_b;
        r_is_div <= bus.funct[1];
        r_neg_q  <= w_neg_a ^ w_neg_b;
        r_neg_r  <= w_neg_a;
        r_dz     <= (bus.src_b == '0);
      end else if (w_accept) begin
        if (w_mt_hi) r_hi <= bus.src_a;
        if (w_mt_lo) r_lo <= bus.src_a;
      end
    end
  end

  assign bus.alu_ctrl = w_ctrl;
  assign bus.illegal  = w_ill;
  assign bus.md_busy  = w_busy;
  assign bus.md_done  = r_done;
  assign bus.stall    = w_busy & bus.issue & w_hilo_op;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
endmodule

// File: tb/tb_alu_control_md.sv
// Bench for alu_control_md (WIDTH=32): directed and random ops against an arithmetic reference.
// Define ALU_MD_FLUSH_EN to also exercise md_flush.
module tb_alu_control_md;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_control_md_if #(.WIDTH(32), .CTRL_W(4)) bus ();

  alu_control_md #(.WIDTH(32), .CTRL_W(4)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decode table: returns {illegal, ctrl}
  function automatic logic [4:0] ref_dec(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b00) return 5'b0_0010;
    if (op == 2'b01) return 5'b0_0110;
    if (op == 2'b11) return 5'b0_0111;
    case (f)
      6'b100100: return 5'b0_0000;
      6'b100101: return 5'b0_0001;
      6'b100000: return 5'b0_0010;
      6'b100010: return 5'b0_0110;
      6'b101010: return 5'b0_0111;
      6'b100110: return 5'b0_0011;
      6'b100111: return 5'b0_1100;
      6'b000000: return 5'b0_1000;
      6'b000010: return 5'b0_1001;
      6'b000011: return 5'b0_1010;
      6'b010000: return 5'b0_1101;
      6'b010010: return 5'b0_1110;
      6'b011000, 6'b011001, 6'b011010, 6'b011011, 6'b010001, 6'b010011: return 5'b0_0000;
      default:   return 5'b1_0000;
    endcase
  endfunction

  function automatic void ref_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] h, output logic [31:0] l);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    h  = '0;
    l  = '0;
    case (f[1:0])
      2'd0: begin p = 64'(sa * sb); {h, l} = p; end
      2'd1: begin p = {32'd0, a} * {32'd0, b}; {h, l} = p; end
      2'd2: begin
        if (b == 32'd0) begin l = 32'hFFFF_FFFF; h = a; end
        else begin l = 32'(sa / sb); h = 32'(sa % sb); end
      end
      default: begin
        if (b == 32'd0) begin l = 32'hFFFF_FFFF; h = a; end
        else begin l = a / b; h = a % b; end
      end
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [1:0] op, input logic [5:0] f, input logic iss,
                        input logic [31:0] a, input logic [31:0] b);
    bus.alu_op = op;
    bus.funct  = f;
    bus.issue  = iss;
    bus.src_a  = a;
    bus.src_b  = b;
  endtask

  task automatic start_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    set_in(2'b10, f, 1'b1, a, b);
    step();
    bus.issue = 1'b0;
  endtask

  task automatic wait_done(output int nb);
    int g;
    nb = 0;
    g  = 0;
    while (bus.md_done !== 1'b1 && g < 200) begin
      if (bus.md_busy === 1'b1) nb++;
      step();
      g++;
    end
    chk("md_done_seen", bus.md_done, 1'b1);
  endtask

  task automatic run_check(input string tag, input logic [5:0] f,
                           input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh, el;
    int nb;
    ref_md(f, a, b, eh, el);
    start_md(f, a, b);
    wait_done(nb);
    chk({tag, "_busy_cycles"}, 64'(nb), 64'd32);
    chk({tag, "_hi"}, bus.hi, eh);
    chk({tag, "_lo"}, bus.lo, el);
    step();
    chk({tag, "_done_pulse"}, bus.md_done, 1'b0);
  endtask

  initial begin
    logic [5:0]  legal_f [12] = '{6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b101010, 6'b100110,
                                  6'b100111, 6'b000000, 6'b000010, 6'b000011, 6'b010000, 6'b010010};
    logic [4:0]  exp_dec;
    logic [31:0] ra, rb, eh, el, keep_hi, keep_lo;
    logic [5:0]  rf;
    logic [1:0]  rop;
    int          nb, sc, dc, g;

    set_in(2'b00, 6'd0, 1'b0, 32'd0, 32'd0);
`ifdef ALU_MD_FLUSH_EN
    bus.md_flush = 1'b0;
`endif
    rst = 1'b1;
    step();
    step();
    chk("rst_busy", bus.md_busy, 1'b0);
    chk("rst_done", bus.md_done, 1'b0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    chk("rst_stall", bus.stall, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Decode
    set_in(2'b10, 6'b100111, 1'b0, 32'd0, 32'd0); #1;
    chk("dec_nor_ctrl", bus.alu_ctrl, 4'b1100);
    chk("dec_nor_ill", bus.illegal, 1'b0);
    set_in(2'b10, 6'b111111, 1'b0, 32'd0, 32'd0); #1;
    chk("dec_bad_ctrl", bus.alu_ctrl, 4'b0000);
    chk("dec_bad_ill", bus.illegal, 1'b1);
    set_in(2'b11, 6'($urandom), 1'b0, 32'd0, 32'd0); #1;
    chk("dec_slt_ctrl", bus.alu_ctrl, 4'b0111);
    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom_range(0, 3));
      rf  = ($urandom_range(0, 1) == 1) ? legal_f[$urandom_range(0, 11)] : 6'($urandom);
      set_in(rop, rf, 1'b0, 32'd0, 32'd0); #1;
      exp_dec = ref_dec(rop, rf);
      chk("dec_rand_ctrl", bus.alu_ctrl, exp_dec[3:0]);
      chk("dec_rand_ill", bus.illegal, exp_dec[4]);
    end
    step();

    // MTHI / MTLO while idle
    set_in(2'b10, 6'b010001, 1'b1, 32'h1234, 32'd0);
    step();
    bus.issue = 1'b0;
    chk("mthi_hi", bus.hi, 32'h1234);
    chk("mthi_done", bus.md_done, 1'b0);
    chk("mthi_busy", bus.md_busy, 1'b0);
    ra = $urandom;
    set_in(2'b10, 6'b010011, 1'b1, ra, 32'd0);
    step();
    bus.issue = 1'b0;
    chk("mtlo_lo", bus.lo, ra);
    chk("mtlo_hi_kept", bus.hi, 32'h1234);

    // Directed multiply/divide
    run_check("mult_m3x7", 6'b011000, 32'hFFFF_FFFD, 32'd7);
    run_check("div_m7d2", 6'b011010, 32'hFFFF_FFF9, 32'd2);
    run_check("divu_7d0", 6'b011011, 32'd7, 32'd0);
    run_check("div_mnd0", 6'b011010, 32'hFFFF_FF00, 32'd0);
    run_check("div_minm1", 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF);
    run_check("mult_min", 6'b011000, 32'h8000_0000, 32'h8000_0000);

    // Random multiply/divide
    for (int i = 0; i < 12; i++) begin
      rf = {4'b0110, 2'($urandom_range(0, 3))};
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 :
           ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 50)) : $urandom;
      if ($urandom_range(0, 1) == 1) ra = ra >> $urandom_range(0, 31);
      run_check("md_rand", rf, ra, rb);
    end

    // Back-to-back issue in the md_done cycle
    ra = $urandom; rb = $urandom;
    ref_md(6'b011001, ra, rb, eh, el);
    start_md(6'b011001, ra, rb);
    wait_done(nb);
    chk("b2b_first_lo", bus.lo, el);
    ra = $urandom; rb = 32'($urandom_range(1, 1000));
    ref_md(6'b011010, ra, rb, eh, el);
    start_md(6'b011010, ra, rb);
    chk("b2b_second_busy", bus.md_busy, 1'b1);
    wait_done(nb);
    chk("b2b_second_cycles", 64'(nb), 64'd32);
    chk("b2b_second_hi", bus.hi, eh);
    chk("b2b_second_lo", bus.lo, el);
    step();

    // Non-HI/LO op while busy, then MFLO stalled until done
    start_md(6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    set_in(2'b10, 6'b100000, 1'b1, 32'd0, 32'd0); #1;
    chk("busy_add_stall", bus.stall, 1'b0);
    chk("busy_add_ctrl", bus.alu_ctrl, 4'b0010);
    step(); step(); step();
    set_in(2'b10, 6'b010010, 1'b1, 32'd0, 32'd0); #1;
    sc = 0; g = 0;
    while (bus.stall === 1'b1 && g < 100) begin
      sc++;
      step();
      g++;
    end
    chk("mflo_stall_cycles", 64'(sc), 64'd29);
    chk("mflo_done_cycle", bus.md_done, 1'b1);
    chk("mflo_lo", bus.lo, 32'h0000_0001);
    chk("mflo_hi", bus.hi, 32'hFFFF_FFFE);
    chk("mflo_ctrl", bus.alu_ctrl, 4'b1110);
    bus.issue = 1'b0;
    step();

    // Reset five cycles into a DIV
    start_md(6'b011010, 32'd1000, 32'd7);
    step(); step(); step(); step();
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_busy", bus.md_busy, 1'b0);
    chk("midrst_hi", bus.hi, 32'd0);
    chk("midrst_lo", bus.lo, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dc = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.md_done === 1'b1) dc++;
    end
    chk("midrst_no_done", 64'(dc), 64'd0);
    chk("midrst_idle", bus.md_busy, 1'b0);

`ifdef ALU_MD_FLUSH_EN
    run_check("pre_flush", 6'b011001, $urandom, $urandom);
    keep_hi = bus.hi;
    keep_lo = bus.lo;
    start_md(6'b011000, $urandom, $urandom);
    for (int i = 0; i < 9; i++) step();
    bus.md_flush = 1'b1;
    step();
    bus.md_flush = 1'b0;
    chk("flush_busy", bus.md_busy, 1'b0);
    chk("flush_hi_kept", bus.hi, keep_hi);
    chk("flush_lo_kept", bus.lo, keep_lo);
    dc = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.md_done === 1'b1) dc++;
    end
    chk("flush_no_done", 64'(dc), 64'd0);
    set_in(2'b10, 6'b011000, 1'b1, 32'd3, 32'd5);
    bus.md_flush = 1'b1;
    step();
    bus.md_flush = 1'b0;
    bus.issue    = 1'b0;
    chk("flush_idle_drop", bus.md_busy, 1'b0);
    step();
`else
    keep_hi = bus.hi;
    keep_lo = bus.lo;
    chk("final_idle_hi", keep_hi, 32'd0);
    chk("final_idle_lo", keep_lo, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_control_md.md
Name: alu_control_md

Overview:
- Parametrised successor to the single-cycle ALU control decoder.
- Decodes ALUOp plus funct into a wider ALU control code covering logic, shift, compare and HI/LO moves.
- Adds an iterative multiply/divide sequencer with HI/LO registers and a stall handshake toward the datapath control.
- Sits between the main control unit and the ALU in the datapath.

Parameters:
- WIDTH, 32: operand, HI and LO width in bits; must be ≥4 and even.
- CTRL_W, 4: width of alu_ctrl; must be ≥4.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- alu_op  in  2  ALUOp from main control.
- funct  in  6  instruction funct field.
- issue  in  1  instruction in execute is valid this cycle.
- src_a  in  WIDTH  rs operand: multiplicand, dividend, MTHI/MTLO source.
- src_b  in  WIDTH  rt operand: multiplier, divisor.
- alu_ctrl  out  CTRL_W  ALU operation code, combinational.
- illegal  out  1  alu_op=10 with an unlisted funct, combinational.
- md_busy  out  1  multiply/divide sequencer running.
- md_done  out  1  one-cycle pulse when HI/LO were just written by a mult/div.
- stall  out  1  hold the pipeline, combinational.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Decode, combinational; alu_ctrl upper bits zero-extended:
  - alu_op 00 → 0010 (ADD); 01 → 0110 (SUB); 11 → 0111 (SLT).
  - alu_op 10, by funct:
    - 100100 → 0000 (AND); 100101 → 0001 (OR); 100000 → 0010 (ADD).
    - 100010 → 0110 (SUB); 101010 → 0111 (SLT); 100110 → 0011 (XOR); 100111 → 1100 (NOR).
    - 000000 → 1000 (SLL); 000010 → 1001 (SRL); 000011 → 1010 (SRA).
    - 010000 → 1101 (MFHI, ALU passes hi); 010010 → 1110 (MFLO, passes lo).
    - 011000–011011 and 010001/010011 → 0000 (mult/div/MTHI/MTLO; ALU result unused).
    - Any other funct → 0000 with illegal=1.
- Multiply/divide ops, alu_op=10 only: 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU.
- Sequencer states: IDLE, RUN. Counter is $clog2(WIDTH)+1 bits wide.
- IDLE → RUN:
  - At the edge where issue=1 and the funct is a mult/div op.
  - Operands are latched as magnitudes for signed ops, and the result sign is recorded.
  - Counter loads WIDTH; md_busy=1 from the following cycle.
- RUN:
  - One iteration per cycle: shift-add for multiply, restoring subtract for divide. Counter decrements.
  - On the edge where the counter reaches 1: HI/LO are written, md_done=1 for the next cycle, md_busy=0, state → IDLE.
  - md_busy is high for exactly WIDTH cycles. The next mult/div may be issued in the cycle md_done is high.
- Results:
  - MULT/MULTU: {hi,lo} = 2·WIDTH-bit product; sign applied by two's-complement negation when signs differ.
  - DIV/DIVU: lo = quotient, hi = remainder. Signed quotient truncates toward zero; remainder takes the dividend's sign.
- Boundary cases:
  - Divide by zero: lo = all ones, hi = src_a. Full WIDTH-cycle latency still applies.
  - Signed most-negative / −1: lo = most-negative value, hi = 0.
- MTHI/MTLO when not busy: hi or lo ← src_a at the issue edge. No md_done pulse, no busy.
- stall = md_busy & issue & (funct ∈ {MFHI, MFLO, MTHI, MTLO, MULT, MULTU, DIV, DIVU}) & alu_op=10.
- While stall=1 the op is not accepted; it is retried by the held pipeline.
- Issue of non-HI/LO ops while busy: no stall, normal decode.
- Reset, at any time including mid-RUN:
  - State IDLE, counter 0, hi=0, lo=0, md_busy=0, md_done=0.
  - The in-flight result is discarded.

Optional Feature:
- Macro: ALU_MD_FLUSH_EN.
- Defined: extra input port md_flush (1 bit).
  - md_flush=1 while in RUN → next edge returns to IDLE, md_busy=0.
  - hi/lo unchanged, no md_done.
  - md_flush in IDLE is ignored and takes priority over a simultaneous issue (issue dropped).
- Undefined: port absent; operations always run to completion.

Test Plan:
- Reset mid-RUN of DIV, 5 cycles in → md_busy=0, hi=lo=0 immediately; no md_done afterwards.
- alu_op=10, funct 100111 → alu_ctrl=1100, illegal=0. funct 111111 → alu_ctrl=0000, illegal=1. alu_op=11 → 0111.
- MULT, src_a=−3 (0xFFFFFFFD), src_b=7, WIDTH=32:
  - md_busy high 32 cycles, then md_done pulse.
  - hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 → lo=0xFFFFFFFF, hi=7.
- MFLO issued 3 cycles after MULTU 0xFFFFFFFF×0xFFFFFFFF:
  - stall=1 until the md_done cycle, then lo=0x00000001 and hi=0xFFFFFFFE.
- MTHI src_a=0x1234 while IDLE → hi=0x1234 next cycle, md_done stays 0. With ALU_MD_FLUSH_EN, md_flush 10 cycles into a MULT → IDLE, hi/lo retain prior values.
